// File: rtl/bin_to_bcd_pkg.sv
// bin_to_bcd_pkg: shared state encoding and digit constants for the sequential BCD converter
package bin_to_bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int BCD_DIGIT_W = 4;
    localparam int ADD3_THRESH = 5;
    localparam int ADD3_VAL = 3;
endpackage

// File: rtl/bin_to_bcd_seq_ctrl_add3_digit.sv
// bcd_add3_digit: double-dabble digit correction, adds 3 when the digit is 5 or more
module bcd_add3_digit
    import bin_to_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);
    assign dout = (din >= BCD_DIGIT_W'(ADD3_THRESH)) ? din + BCD_DIGIT_W'(ADD3_VAL) : din;
endmodule

// File: rtl/bin_to_bcd_seq_ctrl.sv
// bin_to_bcd_seq_ctrl: multi-cycle binary-to-BCD converter, one add-3/shift step per clock; BIN2BCD_ABORT_EN adds an abort input
module bin_to_bcd_seq_ctrl
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [BIN_W-1:0]                bin,
`ifdef BIN2BCD_ABORT_EN
    input  logic                            abort,
`endif
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = BCD_DIGIT_W * DIGITS;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scr_q, scr_d, scr_add;
    logic [SCR_W-1:0]   bcd_q, bcd_d;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3_digit u_add3 (
            .din  (scr_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (scr_add[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Next-state: capture on start, correct-then-shift each SHIFT cycle; the result register is loaded on entry to DONE so it is valid with done
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    shift_d = bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                {scr_d, shift_d} = {scr_add, shift_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                    bcd_d   = scr_d;
                end
`ifdef BIN2BCD_ABORT_EN
                if (abort) begin
                    state_d = IDLE;
                    bcd_d   = bcd_q;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_seq_ctrl.sv
// tb_bin_to_bcd_seq_ctrl: checks the converter (BIN_W=8 and BIN_W=10 instances) against a cycle-age reference model
module tb_bin_to_bcd_seq_ctrl;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       start_s [2] = '{0, 0};
    logic [9:0] bin_s   [2] = '{0, 0};
    logic       abort_s [2] = '{0, 0};
    logic       busy_s  [2];
    logic       done_s  [2];
    logic [11:0] bcd_s  [2];

    int tests = 0;
    int fails = 0;
    int done_cnt [2] = '{0, 0};

    // reference model: age = edges since acceptance, -1 when idle
    int          bw [2] = '{8, 10};
    int          age [2] = '{-1, -1};
    int          cap [2] = '{0, 0};
    logic [11:0] exp_bcd [2] = '{0, 0};

    always #5 clk = ~clk;

    bin_to_bcd_seq_ctrl #(.BIN_W(8), .DIGITS(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .bin(bin_s[0][7:0]),
`ifdef BIN2BCD_ABORT_EN
        .abort(abort_s[0]),
`endif
        .busy(busy_s[0]), .done(done_s[0]), .bcd(bcd_s[0])
    );

    bin_to_bcd_seq_ctrl #(.BIN_W(10), .DIGITS(3)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .bin(bin_s[1]),
`ifdef BIN2BCD_ABORT_EN
        .abort(abort_s[1]),
`endif
        .busy(busy_s[1]), .done(done_s[1]), .bcd(bcd_s[1])
    );

    function automatic logic [11:0] to_bcd(int v);
        logic [11:0] r = '0;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                age[k]     <= -1;
                exp_bcd[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (age[k] < 0) begin
                    if (start_s[k]) begin
                        age[k] <= 0;
                        cap[k] <= (k == 0) ? int'(bin_s[k][7:0]) : int'(bin_s[k]);
                    end
                end else if (abort_s[k] && age[k] < bw[k]) begin
                    age[k] <= -1;
                end else if (age[k] == bw[k]) begin
                    age[k] <= -1;
                end else begin
                    age[k] <= age[k] + 1;
                    if (age[k] + 1 == bw[k]) exp_bcd[k] <= to_bcd(cap[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("busy%0d", k), 32'(busy_s[k]), 32'(age[k] >= 0));
            check($sformatf("done%0d", k), 32'(done_s[k]), 32'(age[k] == bw[k]));
            check($sformatf("bcd%0d", k), 32'(bcd_s[k]), 32'(exp_bcd[k]));
            if (done_s[k]) done_cnt[k]++;
        end
    end

    task automatic wait_done(int k, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done_s[k] && cyc < 40);
        check($sformatf("done_seen%0d", k), 32'(done_s[k]), 32'd1);
    endtask

    task automatic convert(int k, int v, output int cyc);
        @(negedge clk);
        bin_s[k]   = 10'(v);
        start_s[k] = 1;
        @(negedge clk);
        start_s[k] = 0;
        wait_done(k, cyc);
    endtask

    int          sweep [19] = '{0, 2, 3, 5, 8, 10, 32, 48, 80, 128, 160, 17, 34, 51, 85, 136, 170, 204, 255};
    logic [11:0] sweep_exp [19] = '{12'h000, 12'h002, 12'h003, 12'h005, 12'h008, 12'h010, 12'h032,
                                    12'h048, 12'h080, 12'h128, 12'h160, 12'h017, 12'h034, 12'h051,
                                    12'h085, 12'h136, 12'h170, 12'h204, 12'h255};

    initial begin
        int cyc;
        int dc;
        check("pin_255", 32'(to_bcd(255)), 32'h255);
        check("pin_1023", 32'(to_bcd(1023)), 32'h023);
        check("pin_170", 32'(to_bcd(170)), 32'h170);

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_s[0]), 32'd0);
        check("rst_done", 32'(done_s[0]), 32'd0);
        check("rst_bcd", 32'(bcd_s[0]), 32'h000);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check("idle_bcd", 32'(bcd_s[0]), 32'h000);

        // single conversion: busy right after acceptance, done in the 9th cycle
        @(negedge clk);
        bin_s[0]   = 10'd255;
        start_s[0] = 1;
        @(negedge clk);
        start_s[0] = 0;
        check("t2_busy", 32'(busy_s[0]), 32'd1);
        wait_done(0, cyc);
        check("t2_latency", 32'(cyc + 1), 32'd9);
        check("t2_bcd", 32'(bcd_s[0]), 32'h255);

        foreach (sweep[i]) begin
            convert(0, sweep[i], cyc);
            check($sformatf("sweep_%0d", sweep[i]), 32'(bcd_s[0]), 32'(sweep_exp[i]));
        end

        // back-to-back with start held; bin changes mid-flight
        @(negedge clk);
        bin_s[0]   = 10'd99;
        start_s[0] = 1;
        wait_done(0, cyc);
        check("t4_first", 32'(bcd_s[0]), 32'h099);
        repeat (3) @(negedge clk);
        bin_s[0] = 10'd7;
        wait_done(0, cyc);
        check("t4_interval", 32'(cyc + 3), 32'd10);
        check("t4_inflight", 32'(bcd_s[0]), 32'h099);
        wait_done(0, cyc);
        check("t4_next", 32'(bcd_s[0]), 32'h007);
        start_s[0] = 0;
        repeat (3) @(negedge clk);

        // reset at the 4th SHIFT cycle
        @(negedge clk);
        bin_s[0]   = 10'd200;
        start_s[0] = 1;
        @(negedge clk);
        start_s[0] = 0;
        repeat (3) @(negedge clk);
        check("t5_pre_busy", 32'(busy_s[0]), 32'd1);
        dc = done_cnt[0];
        #2 rst_n = 0;
        #1;
        check("t5_rst_busy", 32'(busy_s[0]), 32'd0);
        check("t5_rst_done", 32'(done_s[0]), 32'd0);
        check("t5_rst_bcd", 32'(bcd_s[0]), 32'h000);
        @(negedge clk);
        rst_n = 1;
        repeat (12) @(negedge clk);
        check("t5_no_done", 32'(done_cnt[0]), 32'(dc));
        convert(0, 42, cyc);
        check("t5_42", 32'(bcd_s[0]), 32'h042);

`ifdef BIN2BCD_ABORT_EN
        // abort at the 3rd SHIFT cycle
        @(negedge clk);
        bin_s[0]   = 10'd123;
        start_s[0] = 1;
        @(negedge clk);
        start_s[0] = 0;
        @(negedge clk);
        dc = done_cnt[0];
        abort_s[0] = 1;
        start_s[0] = 1;
        @(negedge clk);
        abort_s[0] = 0;
        start_s[0] = 0;
        check("ab_busy", 32'(busy_s[0]), 32'd0);
        repeat (12) @(negedge clk);
        check("ab_no_done", 32'(done_cnt[0]), 32'(dc));
        check("ab_bcd", 32'(bcd_s[0]), 32'h042);
`endif

        // wider operand wraps modulo 1000
        convert(1, 1023, cyc);
        check("w10_1023", 32'(bcd_s[1]), 32'h023);
        convert(1, 999, cyc);
        check("w10_999", 32'(bcd_s[1]), 32'h999);

        // random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                start_s[k] = ($urandom_range(0, 3) == 0);
                bin_s[k]   = 10'($urandom);
`ifdef BIN2BCD_ABORT_EN
                abort_s[k] = ($urandom_range(0, 15) == 0);
`endif
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 0;
            abort_s[k] = 0;
        end
        repeat (15) @(negedge clk);
        check("final_idle0", 32'(busy_s[0]), 32'd0);
        check("final_idle1", 32'(busy_s[1]), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
